// File: rtl/shift_reg_if.sv
// Control/data bundle for shift_reg: the driver side supplies mode/enable/serial/parallel inputs,
// the register side returns its state plus the flags derived from it.
interface shift_reg_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic             sout_l;
    logic             sout_r;
    logic             zero;

    modport master (
        output en, mode, d, sin_l, sin_r,
        input  q, qn, sout_l, sout_r, zero
    );

    modport slave (
        input  en, mode, d, sin_l, sin_r,
        output q, qn, sout_l, sout_r, zero
    );
endinterface

// File: rtl/shift_reg.sv
// Universal shift register (load/shift/rotate/asr/clear), one-cycle latency, en=0 holds; no backpressure.
// Rotate modes exist only when SHIFT_REG_ROTATE_EN is defined, otherwise modes 100/101 hold.
module shift_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic      clk,
    input  logic      rst,
    shift_reg_if.slave bus
);
    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
`ifdef SHIFT_REG_ROTATE_EN
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
`endif
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_q;
        case (bus.mode)
            M_HOLD: w_next = r_q;
            M_LOAD: w_next = bus.d;
            M_SHL:  w_next = {r_q[WIDTH-2:0], bus.sin_l};
            M_SHR:  w_next = {bus.sin_r, r_q[WIDTH-1:1]};
`ifdef SHIFT_REG_ROTATE_EN
            M_ROL:  w_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            M_ROR:  w_next = {r_q[0], r_q[WIDTH-1:1]};
`endif
            M_ASR:  w_next = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            M_CLR:  w_next = '0;
            // Undefined or disabled encodings keep the current state.
            default: w_next = r_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RST_VAL;
        end else if (bus.en) begin
            r_q <= w_next;
        end
    end

    // Flags look only at the registered state so they move with q and nothing else.
    assign bus.q      = r_q;
    assign bus.qn     = ~r_q;
    assign bus.sout_l = r_q[WIDTH-1];
    assign bus.sout_r = r_q[0];
    assign bus.zero   = (r_q == '0);
endmodule

// File: tb/tb_shift_reg.sv
// Directed bench for shift_reg (WIDTH=8, RST_VAL=0); rotate expectations follow SHIFT_REG_ROTATE_EN.
module tb_shift_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;

    shift_reg_if #(.WIDTH(8)) bus ();

    shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] val);
        bus.en   = 1'b1;
        bus.mode = 3'b001;
        bus.d    = val;
        step();
    endtask

    initial begin
        bus.en    = 1'b0;
        bus.mode  = 3'b000;
        bus.d     = 8'h00;
        bus.sin_l = 1'b0;
        bus.sin_r = 1'b0;
        #1;
        check("por_q", bus.q, 8'h00);
        check("por_zero", {7'b0, bus.zero}, 8'h01);
        step();
        step();
        rst = 1'b0;

        // Async reset between edges, then reset dominating clock edges
        load(8'h3C);
        check("pre_rst_q", bus.q, 8'h3C);
        rst = 1'b1;
        #1;
        check("rst_async_q", bus.q, 8'h00);
        check("rst_async_qn", bus.qn, 8'hFF);
        check("rst_async_zero", {7'b0, bus.zero}, 8'h01);
        bus.en   = 1'b1;
        bus.mode = 3'b001;
        bus.d    = 8'hA5;
        step();
        step();
        check("rst_hold_q", bus.q, 8'h00);
        rst = 1'b0;

        // First edge after release performs the load
        step();
        check("load_q", bus.q, 8'hA5);
        check("load_qn", bus.qn, 8'h5A);
        check("load_zero", {7'b0, bus.zero}, 8'h00);
        bus.en   = 1'b0;
        bus.mode = 3'b111;
        step();
        check("en0_clear_q", bus.q, 8'hA5);
        bus.mode = 3'b001;
        bus.d    = 8'h00;
        step();
        check("en0_load_q", bus.q, 8'hA5);

        // Shift left
        load(8'h81);
        bus.mode  = 3'b010;
        bus.sin_l = 1'b1;
        check("shl_sout_l_pre", {7'b0, bus.sout_l}, 8'h01);
        check("shl_sout_r_pre", {7'b0, bus.sout_r}, 8'h01);
        step();
        check("shl_1", bus.q, 8'h03);
        bus.sin_l = 1'b0;
        step();
        check("shl_2", bus.q, 8'h06);
        bus.en = 1'b0;
        step();
        check("shl_en0", bus.q, 8'h06);

        // Arithmetic vs logical shift right
        load(8'h80);
        bus.mode  = 3'b110;
        bus.sin_r = 1'b0;
        step();
        check("asr_1", bus.q, 8'hC0);
        step();
        check("asr_2", bus.q, 8'hE0);
        load(8'h40);
        bus.mode  = 3'b110;
        bus.sin_r = 1'b1;
        step();
        check("asr_ign_sin", bus.q, 8'h20);
        load(8'h80);
        bus.mode  = 3'b011;
        bus.sin_r = 1'b0;
        step();
        check("lsr_1", bus.q, 8'h40);
        bus.sin_r = 1'b1;
        step();
        check("lsr_sin1", bus.q, 8'hA0);
        bus.mode = 3'b000;
        step();
        check("hold_mode", bus.q, 8'hA0);

        // Rotate (serial inputs held low so a plain shift would differ)
        load(8'h01);
        bus.mode  = 3'b101;
        bus.sin_l = 1'b0;
        bus.sin_r = 1'b0;
        step();
`ifdef SHIFT_REG_ROTATE_EN
        check("ror_1", bus.q, 8'h80);
`else
        check("ror_1", bus.q, 8'h01);
`endif
        step();
`ifdef SHIFT_REG_ROTATE_EN
        check("ror_2", bus.q, 8'h40);
`else
        check("ror_2", bus.q, 8'h01);
`endif
        load(8'h81);
        bus.mode = 3'b100;
        step();
`ifdef SHIFT_REG_ROTATE_EN
        check("rol_1", bus.q, 8'h03);
`else
        check("rol_1", bus.q, 8'h81);
`endif

        // Clear and zero flag
        load(8'hFF);
        check("ff_zero", {7'b0, bus.zero}, 8'h00);
        bus.mode = 3'b111;
        step();
        check("clr_q", bus.q, 8'h00);
        check("clr_zero", {7'b0, bus.zero}, 8'h01);
        bus.mode  = 3'b010;
        bus.sin_l = 1'b1;
        step();
        check("post_clr_q", bus.q, 8'h01);
        check("post_clr_zero", {7'b0, bus.zero}, 8'h00);

        // Reset in the middle of a shift sequence leaves nothing behind
        load(8'hF0);
        bus.mode  = 3'b010;
        bus.sin_l = 1'b1;
        step();
        check("mid_shift", bus.q, 8'hE1);
        rst = 1'b1;
        #1;
        check("mid_rst_q", bus.q, 8'h00);
        step();
        check("mid_rst_edge", bus.q, 8'h00);
        rst = 1'b0;
        step();
        check("post_rst_shl", bus.q, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/shift_reg.md
SHIFT_REG -- requirements
Module: shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter RST_VAL, default 0 (WIDTH bits), value loaded into the register on reset.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port en  input  1  synchronous enable; 0 means hold regardless of mode.
REQ-006 The block SHALL have port mode  input  3  operation select, encoding per REQ-012.
REQ-007 The block SHALL have port d  input  WIDTH  parallel load data.
REQ-008 The block SHALL have port sin_l  input  1  serial in; enters bit 0 on shift left.
REQ-009 The block SHALL have port sin_r  input  1  serial in; enters bit WIDTH-1 on logical shift right.
REQ-010 The block SHALL have ports q  output  WIDTH  register state, and qn  output  WIDTH  bitwise complement of q.
REQ-011 The block SHALL have ports sout_l  output  1  equal to q[WIDTH-1]; sout_r  output  1  equal to q[0]; zero  output  1  high when q is all zeros.

Function
REQ-012 Mode encoding SHALL be: 000 hold; 001 parallel load d; 010 shift left (q = {q[WIDTH-2:0], sin_l}); 011 logical shift right (q = {sin_r, q[WIDTH-1:1]}); 100 rotate left; 101 rotate right; 110 arithmetic shift right (MSB replicated); 111 clear to all zeros.
REQ-013 Every update SHALL take effect on the rising clk edge where en=1, with one-cycle latency from inputs to q.
REQ-014 When en=0, q SHALL hold its value for all modes, including load and clear.
REQ-015 qn, sout_l, sout_r and zero SHALL be derived combinationally from the registered q only, never from d or mode, so they change only with q.
REQ-016 Rotate SHALL ignore sin_l and sin_r: rotate left moves q[WIDTH-1] to bit 0; rotate right moves q[0] to bit WIDTH-1.
REQ-017 Before the edge, sout_l and sout_r SHALL show the bit that a left or right shift on that edge discards.
REQ-018 Arithmetic shift right SHALL ignore sin_r.
REQ-019 An unknown or undefined mode value SHALL not corrupt q. An X on mode with en=1 is a bench error, not a design requirement.

Reset
REQ-020 When rst is asserted, q SHALL take RST_VAL immediately, without a clock edge. qn SHALL be ~RST_VAL and zero SHALL be (RST_VAL==0).
REQ-021 While rst=1, clock edges SHALL have no effect, whatever the values of en and mode.
REQ-022 On rst deassertion, the first rising edge with en=1 SHALL perform the selected mode normally. No extra wait cycle is inserted.
REQ-023 A reset asserted in the middle of a multi-cycle shift sequence SHALL abort it with no residual state.

Configuration
REQ-024 Macro SHIFT_REG_ROTATE_EN SHALL control the rotate modes. When defined, modes 100 and 101 rotate per REQ-016.
REQ-025 When SHIFT_REG_ROTATE_EN is not defined, modes 100 and 101 SHALL behave as hold (000), and no rotate logic is synthesised.

Verification
REQ-026 The bench SHALL cover reset. WIDTH=8, q=3C, assert rst between edges -> q=00 before the next edge, qn=FF, zero=1; edges with en=1, mode=001 and rst=1 leave q=00.
REQ-027 The bench SHALL cover load and hold. en=1, mode=001, d=A5 -> q=A5, qn=5A, zero=0 after one edge; then en=0, mode=111 -> q remains A5.
REQ-028 The bench SHALL cover shift left. q=81, sin_l=1, mode=010 -> before the edge sout_l=1; after the edge q=03; a second edge with sin_l=0 gives q=06.
REQ-029 The bench SHALL cover arithmetic versus logical shift right. q=80, mode=110, sin_r=0 -> C0, then E0; q=80, mode=011, sin_r=0 -> 40.
REQ-030 The bench SHALL cover rotate under both builds. q=01, mode=101: with SHIFT_REG_ROTATE_EN -> 80, then 40; without the macro -> q stays 01.
REQ-031 The bench SHALL cover clear and the zero flag. q=FF, mode=111, en=1 -> q=00, zero=1; then mode=010, sin_l=1 -> q=01, zero=0.
